// File: rtl/output_display_pkg.sv
// output_display_pkg: FSM states, digit count, seven-segment patterns and the double-dabble adjust helper.
package output_display_pkg;
   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
   localparam int NUM_DIGITS = 3;
   localparam logic [6:0] SEG_0 = 7'b0111111;
   localparam logic [6:0] SEG_1 = 7'b0000110;
   localparam logic [6:0] SEG_2 = 7'b1011011;
   localparam logic [6:0] SEG_3 = 7'b1001111;
   localparam logic [6:0] SEG_4 = 7'b1100110;
   localparam logic [6:0] SEG_5 = 7'b1101101;
   localparam logic [6:0] SEG_6 = 7'b1111101;
   localparam logic [6:0] SEG_7 = 7'b0000111;
   localparam logic [6:0] SEG_8 = 7'b1111111;
   localparam logic [6:0] SEG_9 = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   function automatic logic [3:0] dd_adj(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction
endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: BCD digit to active-high {g,f,e,d,c,b,a}; blank or non-decimal input gives all segments off.
module seg7_decoder
   import output_display_pkg::*;
(
   input  logic [3:0] i_digit,
   input  logic       i_blank,
   output logic [6:0] o_seg
);
   always_comb begin
      o_seg = SEG_BLANK;
      if (!i_blank)
         case (i_digit)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
         endcase
   end
endmodule

// File: rtl/output_display.sv
// output_display: latches the bus byte, converts it to BCD by double dabble and scans three 7-segment digits.
// Define LEADING_ZERO_BLANK_EN to blank leading zero hundreds/tens digits.
module output_display
   import output_display_pkg::*;
#(
   parameter int REFRESH_DIV = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [7:0] bus,
   output logic [7:0] value,
   output logic       busy,
   output logic [2:0] an,
   output logic [6:0] seg
);
   state_t      r_state, w_next;
   logic [7:0]  r_value, r_bin;
   logic [11:0] r_bcd;
   logic [2:0]  r_iter;
   logic [3:0]  r_d0, r_d1, r_d2, w_digit;
   logic [15:0] r_refresh;
   logic [1:0]  r_idx;
   logic        w_blank;

   always_ff @(posedge clk or posedge reset)
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;

   // A load in any state restarts the conversion from the first iteration.
   always_comb begin
      w_next = r_state;
      if (load)                                  w_next = CONV;
      else if (r_state == CONV && r_iter == 3'd7) w_next = DONE;
      else if (r_state == DONE)                  w_next = IDLE;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_value <= '0;
         r_bin   <= '0;
         r_bcd   <= '0;
         r_iter  <= '0;
         r_d0    <= '0;
         r_d1    <= '0;
         r_d2    <= '0;
      end else if (load) begin
         r_value <= bus;
         r_bin   <= bus;
         r_bcd   <= '0;
         r_iter  <= '0;
      end else if (r_state == CONV) begin
         {r_bcd, r_bin} <= {dd_adj(r_bcd[11:8]), dd_adj(r_bcd[7:4]), dd_adj(r_bcd[3:0]), r_bin} << 1;
         r_iter <= r_iter + 3'd1;
      end else if (r_state == DONE)
         {r_d2, r_d1, r_d0} <= r_bcd;

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_refresh <= '0;
         r_idx     <= '0;
      end else if (r_refresh == 16'(REFRESH_DIV - 1)) begin
         r_refresh <= '0;
         r_idx     <= (r_idx == 2'(NUM_DIGITS - 1)) ? 2'd0 : r_idx + 2'd1;
      end else
         r_refresh <= r_refresh + 16'd1;

   assign value   = r_value;
   assign busy    = (r_state != IDLE);
   assign an      = 3'b001 << r_idx;
   assign w_digit = (r_idx == 2'd2) ? r_d2 : (r_idx == 2'd1) ? r_d1 : r_d0;
`ifdef LEADING_ZERO_BLANK_EN
   assign w_blank = (r_idx == 2'd2 && r_d2 == 4'd0) || (r_idx == 2'd1 && r_d2 == 4'd0 && r_d1 == 4'd0);
`else
   assign w_blank = 1'b0;
`endif

   seg7_decoder u_dec (
      .i_digit(w_digit),
      .i_blank(w_blank),
      .o_seg  (seg)
   );
endmodule

// File: tb/tb_output_display.sv
// tb_output_display: randomized loads against a decimal reference model with a queue-based scoreboard.
module tb_output_display;
   logic       clk = 1'b0, reset = 1'b0, load = 1'b0;
   logic [7:0] bus = '0;
   logic [7:0] value;
   logic       busy;
   logic [2:0] an;
   logic [6:0] seg;

   typedef struct { int v; int done; } exp_t;
   exp_t q[$];
   exp_t e;
   int   k = 0, shown = 0, total = 0, bad = 0;
   logic prev_busy = 1'b0;
   logic [6:0] segtab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

   output_display #(.REFRESH_DIV(4)) dut (
      .clk(clk), .reset(reset), .load(load), .bus(bus),
      .value(value), .busy(busy), .an(an), .seg(seg)
   );

   always #5 clk = ~clk;

   // edges since reset released: drives both the scan model and load latency bookkeeping
   always @(posedge clk or posedge reset)
      if (reset) k <= 0;
      else       k <= k + 1;

   task automatic chk(input string name, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, want, k);
      end
   endtask

   function automatic logic [6:0] exp_seg(input int v, input int idx);
      int d;
      d = (idx == 0) ? v % 10 : (idx == 1) ? (v / 10) % 10 : v / 100;
`ifdef LEADING_ZERO_BLANK_EN
      if ((idx == 2 && v < 100) || (idx == 1 && v < 10)) return 7'b0000000;
`endif
      return segtab[d];
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         q.delete();
         shown = 0;
         prev_busy = 1'b0;
      end else begin
         chk("busy", int'(busy), (q.size() > 0 && q[$].done > k) ? 1 : 0);
         if (prev_busy && !busy) begin
            chk("done_pending", q.size(), 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("latency", k, e.done);
               chk("value", int'(value), e.v);
               shown = e.v;
            end
         end
         prev_busy = busy;
         chk("an", int'(an), 1 << ((k / 4) % 3));
         chk("seg", int'(seg), int'(exp_seg(shown, (k / 4) % 3)));
      end
   end

   task automatic do_load(input int v);
      @(negedge clk); #1;
      if (q.size() > 0 && q[$].done >= k + 1) void'(q.pop_back());
      q.push_back('{v, k + 10});
      load = 1'b1;
      bus  = 8'(v);
      @(negedge clk); #1 load = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_an", int'(an), 1);
      chk("rst_seg", int'(seg), int'(segtab[0]));
      chk("rst_value", int'(value), 0);
      repeat (2) @(negedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      @(negedge clk); #1;
      apply_reset();
      idle(3);
      do_load(255);
      idle(20);
      do_load(100);
      idle(1);
      do_load(42);
      idle(25);
      do_load(7);
      idle(20);
      do_load(200);
      idle(3);
      apply_reset();
      idle(20);
      idle(40);
      foreach (segtab[i]) begin
         do_load(i * 11);
         idle(12);
      end
      do_load(0);
      idle(14);
      do_load(99);
      idle(14);
      repeat (30) begin
         do_load(int'($urandom_range(0, 255)));
         idle(int'($urandom_range(0, 15)));
      end
      idle(25);
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
